// File: rtl/ltc2333_pkg.sv
// Shared types and helpers for the LTC2333 conversion sequencer.
package ltc2333_pkg;

  localparam int unsigned N_CH   = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned SPAN_W = 3;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned OVR_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CNV   = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  // SoftSpan control word shifted MSB first onto SDI.
  function automatic logic [WORD_W-1:0] ctrl_word(input logic [CH_W-1:0] ch,
                                                  input logic [SPAN_W-1:0] span);
    return {1'b1, ch, span, 1'b0};
  endfunction

endpackage

// File: rtl/ltc2333_next_chan.sv
// Round-robin search for the next enabled channel strictly after cur, wrapping 7->0.
module ltc2333_next_chan
  import ltc2333_pkg::*;
(
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] cur,
  output logic [CH_W-1:0] nxt
);

  logic [CH_W-1:0] idx;
  logic            found;

  // Falls back to cur when no other channel is enabled.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i < N_CH; i++) begin
      idx = cur + CH_W'(i);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ltc2333_conv_ctrl.sv
// LTC2333 conversion sequencer: CNV pulse, BUSY wait, SCKI burst and SDI control word.
module ltc2333_conv_ctrl
  import ltc2333_pkg::*;
#(
  parameter int unsigned SCK_HALF     = 2,
  parameter int unsigned SCK_PERIODS  = 12,
  parameter int unsigned CNV_HIGH     = 4,
  parameter int unsigned CONV_MIN     = 90,
  parameter int unsigned CONV_TIMEOUT = 200,
  parameter int unsigned PERIOD_W     = 24
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic                   trig_sel,
  input  logic                   trig_ext,
  input  logic [PERIOD_W-1:0]    period,
  input  logic [N_CH-1:0]        chan_mask,
  input  logic [N_CH*SPAN_W-1:0] span_cfg,
  input  logic                   busy,
  output logic                   cnv,
  output logic                   scki,
  output logic                   sdi,
  output logic                   active,
  output logic [CH_W-1:0]        cur_chan,
  output logic                   conv_done,
  output logic [OVR_W-1:0]       overrun_cnt,
  output logic                   timeout_err
);

  localparam int unsigned CNT_W  = $clog2(CONV_TIMEOUT + 1);
  localparam int unsigned HALF_W = $clog2(SCK_HALF + 1);
  localparam int unsigned HP_N   = 2 * SCK_PERIODS;
  localparam int unsigned HP_W   = $clog2(HP_N + 1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [HALF_W-1:0]   hcnt, hcnt_d;
  logic [HP_W-1:0]     hp, hp_d;
  logic [WORD_W-1:0]   word, word_d;
  logic [CH_W-1:0]     nxt_lat, nxt_lat_d, nxt;
  logic [CH_W-1:0]     cur_chan_d;
  logic                cnv_d, scki_d, sdi_d, active_d, conv_done_d, timeout_d;
  logic [OVR_W-1:0]    overrun_d;
  logic [SPAN_W-1:0]   span_sel;
  logic                busy_meta, busy_sync, trig_q, tmr_wrap, trg;
  logic [PERIOD_W-1:0] timer;

  ltc2333_next_chan u_next_chan (
    .mask (chan_mask),
    .cur  (cur_chan),
    .nxt  (nxt)
  );

  assign span_sel = span_cfg[{2'b00, nxt} * 5'd3 +: SPAN_W];
  assign tmr_wrap = (timer == period - PERIOD_W'(1));
  assign trg      = trig_sel ? (enable && (period != '0) && tmr_wrap)
                             : (trig_ext && !trig_q);

  // Trigger sources and BUSY synchronizer.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      busy_meta <= 1'b0;
      busy_sync <= 1'b0;
      trig_q    <= 1'b0;
      timer     <= '0;
    end else begin
      busy_meta <= busy;
      busy_sync <= busy_meta;
      trig_q    <= trig_ext;
      if (enable && (period != '0)) timer <= tmr_wrap ? '0 : timer + PERIOD_W'(1);
      else                          timer <= '0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      cnt         <= '0;
      hcnt        <= '0;
      hp          <= '0;
      word        <= '0;
      nxt_lat     <= '0;
      cnv         <= 1'b0;
      scki        <= 1'b0;
      sdi         <= 1'b0;
      active      <= 1'b0;
      cur_chan    <= '0;
      conv_done   <= 1'b0;
      overrun_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      hcnt        <= hcnt_d;
      hp          <= hp_d;
      word        <= word_d;
      nxt_lat     <= nxt_lat_d;
      cnv         <= cnv_d;
      scki        <= scki_d;
      sdi         <= sdi_d;
      active      <= active_d;
      cur_chan    <= cur_chan_d;
      conv_done   <= conv_done_d;
      overrun_cnt <= overrun_d;
      timeout_err <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    hcnt_d      = hcnt;
    hp_d        = hp;
    word_d      = word;
    nxt_lat_d   = nxt_lat;
    cur_chan_d  = cur_chan;
    conv_done_d = 1'b0;
    timeout_d   = timeout_err;
    overrun_d   = overrun_cnt;
    sdi_d       = sdi;

    if (trg && enable && (state != IDLE) && (overrun_cnt != '1))
      overrun_d = overrun_cnt + OVR_W'(1);

    unique case (state)
      IDLE: begin
        if (trg && enable && (chan_mask != '0)) begin
          state_d = CNV;
          cnt_d   = '0;
        end
      end
      CNV: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(CNV_HIGH - 1)) state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if ((cnt >= CNT_W'(CONV_MIN)) && !busy_sync) begin
          state_d   = SHIFT;
          hcnt_d    = '0;
          hp_d      = '0;
          word_d    = ctrl_word(nxt, span_sel);
          nxt_lat_d = nxt;
        end else if (cnt == CNT_W'(CONV_TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      SHIFT: begin
        if (hcnt == HALF_W'(SCK_HALF - 1)) begin
          hcnt_d = '0;
          hp_d   = hp + HP_W'(1);
          if (hp == HP_W'(HP_N - 1)) state_d = DONE;
        end else begin
          hcnt_d = hcnt + HALF_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state == SHIFT) && (state_d == DONE)) begin
      conv_done_d = 1'b1;
      cur_chan_d  = nxt_lat;
    end

    cnv_d    = (state_d == CNV);
    active_d = (state_d != IDLE);
    scki_d   = (state_d == SHIFT) && hp_d[0];

    // Next SDI bit appears in the last low cycle before each rising edge; zeros after the word.
    if (state_d != SHIFT) begin
      sdi_d = 1'b0;
    end else if (!hp_d[0] && (hcnt_d == HALF_W'(SCK_HALF - 1))) begin
      sdi_d  = word_d[WORD_W-1];
      word_d = word_d << 1;
    end
  end

endmodule

// File: tb/tb_ltc2333_conv_ctrl.sv
// Scoreboard bench for ltc2333_conv_ctrl with a behavioural ADC BUSY model.
`timescale 1ns/1ps
module tb_ltc2333_conv_ctrl;

  localparam int unsigned BUSY_LOW  = 100;
  localparam int unsigned SCK_HALF  = 2;
  localparam int unsigned SCK_PER   = 12;
  localparam int unsigned CNV_HIGH  = 4;
  localparam int unsigned TIMEOUT   = 200;
  // trigger cycle -> back in IDLE: CNV delay, BUSY, 2-FF sync + decision, SCKI burst, DONE
  localparam int unsigned CYCLE_LEN = 1 + BUSY_LOW + 3 + 2 * SCK_HALF * SCK_PER + 1;

  logic        clk = 1'b0;
  logic        aresetn, enable, trig_sel, trig_ext, busy;
  logic [23:0] period;
  logic [7:0]  chan_mask;
  logic [23:0] span_cfg;
  logic        cnv, scki, sdi, active, conv_done, timeout_err;
  logic [2:0]  cur_chan;
  logic [15:0] overrun_cnt;

  ltc2333_conv_ctrl dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .trig_sel(trig_sel),
    .trig_ext(trig_ext), .period(period), .chan_mask(chan_mask), .span_cfg(span_cfg),
    .busy(busy), .cnv(cnv), .scki(scki), .sdi(sdi), .active(active),
    .cur_chan(cur_chan), .conv_done(conv_done), .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] chan;
    logic [7:0] word;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned m_cur  = 0;
  int unsigned m_ovr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Walk the channel ring once starting just after cur; stay on cur if nothing else is enabled.
  function automatic int unsigned model_next(input int unsigned cur, input logic [7:0] mask);
    int unsigned c = cur;
    repeat (7) begin
      c = (c == 7) ? 0 : c + 1;
      if (mask[c]) return c;
    end
    return cur;
  endfunction

  task automatic push_expect(input logic [7:0] mask, input logic [23:0] span);
    exp_t        e;
    int unsigned n = model_next(m_cur, mask);
    logic [23:0] s = span >> (3 * n);
    e.chan = 3'(n);
    e.word = {1'b1, e.chan, s[2:0], 1'b0};
    sb.push_back(e);
    m_cur = n;
  endtask

  // ADC BUSY: high from CNV rise for BUSY_LOW cycles, or held high on demand.
  bit busy_hold = 1'b0;
  initial begin
    int   bt = 0;
    logic bprev = 1'b0;
    busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!aresetn) begin
        busy = 1'b0; bt = 0;
      end else begin
        if (cnv && !bprev) begin busy = 1'b1; bt = BUSY_LOW; end
        else if (bt > 0) bt--;
        if (bt == 0 && !busy_hold) busy = 1'b0;
      end
      bprev = cnv;
    end
  end

  // Monitor: captures SDI at SCKI rises, pops the scoreboard on every conv_done.
  int         cyc = 0, edges = 0, gedges = 0, done_cnt = 0, cnv_rises = 0, cnv_len = 0, last_edge = 0;
  logic [11:0] cap = '0;
  logic       prev_scki = 1'b0, prev_cnv = 1'b0, pend = 1'b0;
  logic [2:0] pend_chan = '0;
  exp_t       me;
  always @(negedge clk) begin
    cyc++;
    if (!aresetn) begin
      edges = 0; cap = '0; prev_scki = 1'b0; prev_cnv = 1'b0; cnv_len = 0; pend = 1'b0;
    end else begin
      if (pend) begin check("cur_chan_after_done", cur_chan, pend_chan); pend = 1'b0; end
      if (scki && !prev_scki) begin
        if (edges > 0) check("scki_period", cyc - last_edge, 2 * SCK_HALF);
        last_edge = cyc;
        if (edges < 12) cap = {cap[10:0], sdi};
        edges++; gedges++;
      end
      if (cnv) cnv_len++;
      if (cnv && !prev_cnv) cnv_rises++;
      if (!cnv && prev_cnv) begin check("cnv_width", cnv_len, CNV_HIGH); cnv_len = 0; end
      if (conv_done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_conv_done: got conv_done=1 expected none at cycle %0d", cyc);
        end else begin
          me = sb.pop_front();
          check("scki_edges", edges, SCK_PER);
          check("sdi_word", cap, {me.word, 4'b0000});
          pend = 1'b1; pend_chan = me.chan;
        end
        edges = 0; cap = '0;
      end
      prev_scki = scki; prev_cnv = cnv;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ext();
    trig_ext = 1'b1; tick(); trig_ext = 1'b0;
  endtask

  task automatic wait_sb(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin tick(); n++; end
    tick(2);
    check(name, sb.size(), 0);
  endtask

  task automatic wait_edges(input int target, input int budget);
    int n = 0;
    while (gedges < target && n < budget) begin tick(); n++; end
    check("scki_edge_wait", gedges >= target, 1'b1);
  endtask

  initial begin
    int g0, r0, d0, n, free_at;
    aresetn = 1'b0; enable = 1'b0; trig_sel = 1'b0; trig_ext = 1'b0;
    period = '0; chan_mask = '0; span_cfg = '0;
    tick(3);
    check("rst_cnv", cnv, 0);           check("rst_scki", scki, 0);
    check("rst_sdi", sdi, 0);           check("rst_active", active, 0);
    check("rst_cur_chan", cur_chan, 0); check("rst_conv_done", conv_done, 0);
    check("rst_overrun", overrun_cnt, 0); check("rst_timeout", timeout_err, 0);
    aresetn = 1'b1; tick(2);

    // Timer mode, all channels: sequence 1..7,0
    chan_mask = 8'hFF; span_cfg = 24'($urandom()); trig_sel = 1'b1; period = 24'd500;
    for (int i = 0; i < 8; i++) push_expect(chan_mask, span_cfg);
    d0 = done_cnt;
    enable = 1'b1;
    wait_sb(4800, "timer_mode_done");
    enable = 1'b0;
    check("timer_done_count", done_cnt - d0, 8);
    check("timer_overrun", overrun_cnt, m_ovr);
    check("timer_cur_chan", cur_chan, 0);

    // External trigger, mask 0x05, ch2 span 111 -> word 1_010_111_0
    trig_sel = 1'b0; period = '0; chan_mask = 8'h05;
    span_cfg = 24'($urandom()); span_cfg[8:6] = 3'b111;
    enable = 1'b1; tick();
    push_expect(chan_mask, span_cfg);
    check("ext_expected_word", sb[0].word, 8'hAE);
    pulse_ext();
    check("cnv_latency", cnv, 1);
    wait_sb(400, "ext_done");
    check("ext_cur_chan", cur_chan, 2);

    // Period 50 with ~153-cycle conversions: dropped triggers counted
    chan_mask = 8'hFF; span_cfg = 24'($urandom());
    enable = 1'b0; trig_sel = 1'b1; period = 24'd50; tick();
    free_at = 0;
    for (int t = 49; t < 1025; t += 50) begin
      if (t >= free_at) begin push_expect(chan_mask, span_cfg); free_at = t + CYCLE_LEN; end
      else m_ovr++;
    end
    enable = 1'b1; tick(1025); enable = 1'b0;
    wait_sb(400, "overrun_phase_done");
    check("overrun_count", overrun_cnt, m_ovr);

    // BUSY stuck high -> timeout at CNV rise + 200
    trig_sel = 1'b0; period = '0; enable = 1'b1; busy_hold = 1'b1; tick();
    g0 = gedges;
    pulse_ext();
    check("timeout_cnv_rise", cnv, 1);
    tick(TIMEOUT - 2);
    check("timeout_not_early", timeout_err, 0);
    tick(3);
    check("timeout_set", timeout_err, 1);
    check("timeout_idle", active, 0);
    check("timeout_no_scki", gedges - g0, 0);
    check("timeout_cur_chan", cur_chan, 3'(m_cur));
    busy_hold = 1'b0; tick(3);
    push_expect(chan_mask, span_cfg);
    pulse_ext();
    wait_sb(400, "after_timeout_done");
    check("timeout_sticky", timeout_err, 1);

    // Empty mask: triggers ignored, not counted
    chan_mask = 8'h00; r0 = cnv_rises;
    repeat (3) begin pulse_ext(); tick(5); end
    tick(5);
    check("mask0_no_cnv", cnv_rises - r0, 0);
    check("mask0_overrun", overrun_cnt, m_ovr);
    check("mask0_idle", active, 0);

    // Reset asserted while SCKI is high during SHIFT
    chan_mask = 8'hFF;
    pulse_ext();
    wait_edges(gedges + 3, 400);
    n = 0;
    while (scki !== 1'b1 && n < 20) begin tick(); n++; end
    check("reset_probe_scki_high", scki, 1);
    aresetn = 1'b0; #1;
    check("midrst_cnv", cnv, 0);       check("midrst_scki", scki, 0);
    check("midrst_sdi", sdi, 0);       check("midrst_active", active, 0);
    check("midrst_overrun", overrun_cnt, 0); check("midrst_timeout", timeout_err, 0);
    check("midrst_cur_chan", cur_chan, 0);
    sb.delete(); m_cur = 0; m_ovr = 0;
    tick(2); aresetn = 1'b1; tick(2);

    // Mask changed during SHIFT only affects the following cycle
    chan_mask = 8'h01; span_cfg = 24'($urandom());
    push_expect(chan_mask, span_cfg);
    pulse_ext();
    wait_edges(gedges + 2, 400);
    chan_mask = 8'h80; span_cfg = 24'($urandom());
    wait_sb(400, "mask_change_first");
    check("mask_change_cur0", cur_chan, 0);
    push_expect(chan_mask, span_cfg);
    pulse_ext();
    wait_sb(400, "mask_change_second");
    check("mask_change_cur7", cur_chan, 7);

    // Randomized masks and spans
    repeat (6) begin
      chan_mask = 8'($urandom_range(1, 255)); span_cfg = 24'($urandom());
      push_expect(chan_mask, span_cfg);
      pulse_ext();
      wait_sb(400, "random_done");
      tick(2 + $urandom_range(0, 5));
    end
    check("final_overrun", overrun_cnt, m_ovr);
    check("final_cur_chan", cur_chan, 3'(m_cur));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ltc2333_conv_ctrl.md
Name: ltc2333_conv_ctrl

Overview:
- Sequencer that drives the LTC2333 ADC conversion and serial-clock pins for the existing LTC2333 readout/deserializer block.
- Per trigger it performs one conversion cycle:
  - issues a CNV pulse;
  - waits for BUSY to fall;
  - generates the SCKI burst that clocks one 24-bit result out;
  - shifts the SoftSpan control word for the next enabled channel onto SDI.
- Sits between the IPIF register wrapper (which supplies config ports) and the ADC pins. SCKO/SDO return directly to the readout block.

Parameters:
- SCK_HALF, 2, SCKI half-period in clk cycles (≥1).
- SCK_PERIODS, 12, SCKI periods per conversion. Readout captures DDR, so 12 periods = 24 bits.
- CNV_HIGH, 4, CNV high time in clk cycles (≥1).
- CONV_MIN, 90, clk cycles after CNV rise before BUSY is sampled.
- CONV_TIMEOUT, 200, clk cycles after CNV rise before abandoning the wait for BUSY low.
- PERIOD_W, 24, width of the internal trigger period register.

Ports:
- clk  in  1  system clock; all logic on posedge.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  run enable. When low, new triggers are ignored; any cycle in flight completes.
- trig_sel  in  1  trigger source: 0 = trig_ext, 1 = internal period timer.
- trig_ext  in  1  external trigger, synchronous to clk; rising edge fires.
- period  in  PERIOD_W  internal timer period in clk cycles; 0 disables the timer.
- chan_mask  in  8  enabled channels; bit n = channel n.
- span_cfg  in  24  SoftSpan code per channel; bits [3n+2:3n] = channel n.
- busy  in  1  ADC BUSY pin, asynchronous; 2-FF synchronized internally.
- cnv  out  1  ADC CNV pin.
- scki  out  1  ADC SCKI pin.
- sdi  out  1  ADC SDI pin.
- active  out  1  high whenever the FSM is not IDLE.
- cur_chan  out  3  channel of the conversion in progress or last completed.
- conv_done  out  1  one-cycle pulse at the end of each completed cycle.
- overrun_cnt  out  16  count of triggers dropped while active; saturates at 0xFFFF.
- timeout_err  out  1  sticky; set on BUSY timeout, cleared only by reset.

Behaviour:
- Reset values: cnv=0, scki=0, sdi=0, active=0, cur_chan=0, conv_done=0, overrun_cnt=0, timeout_err=0, timer=0, state=IDLE.
- Trigger pulse (trg):
  - trig_sel=0: trg = rising edge of trig_ext (registered previous value).
  - trig_sel=1: timer counts 0..period-1; trg fires on the cycle it wraps to 0. Timer runs only while enable=1 and period≠0, and resets to 0 otherwise.
- A trigger is accepted only when state=IDLE, enable=1 and chan_mask≠0.
- A trigger arriving with state≠IDLE increments overrun_cnt and is dropped.
- A trigger arriving with chan_mask=0 is ignored silently (no count).
- FSM states and transitions:
  - IDLE: on accepted trg go to CNV. cnv rises the cycle after trg.
  - CNV: cnv=1 for exactly CNV_HIGH cycles, then go to WAIT.
  - WAIT: wait counter runs from CNV rise.
    - Once counter ≥ CONV_MIN and busy_sync=0, go to SHIFT.
    - If counter reaches CONV_TIMEOUT first: set timeout_err and go to IDLE. No SCKI, no conv_done, channel not advanced.
  - SHIFT:
    - scki toggles every SCK_HALF cycles, starting low and rising first.
    - Exactly SCK_PERIODS rising edges; scki ends low. Then go to DONE.
  - DONE: conv_done=1 for one cycle; cur_chan ← nxt; go to IDLE.
- Channel sequence:
  - nxt = first set bit of chan_mask strictly after cur_chan, searching upward with wrap 7→0. If only cur_chan is set, nxt = cur_chan.
  - chan_mask and span_cfg are sampled once at WAIT→SHIFT. Later changes affect the following cycle only.
  - The first conversion after reset converts channel 0 with the ADC's power-on config. Data ordering is therefore "result of cur_chan, program nxt".
- SDI control word, 8 bits, MSB first: {1'b1, nxt[2:0], span_cfg[3*nxt+:3], 1'b0}.
  - Bit k is driven on sdi from the cycle before SCKI rising edge k until the cycle before edge k+1 (k=0..7).
  - sdi=0 for the remaining periods and outside SHIFT.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous reset); cnv and scki drop within the same cycle.
- enable deasserted mid-cycle: the cycle completes normally.

Decomposition:
- Package ltc2333_pkg:
  - enum state_t {IDLE, CNV, WAIT, SHIFT, DONE};
  - function ctrl_word(ch, span) returning 8 bits;
  - localparam N_CH=8.
- Sub-module ltc2333_next_chan: combinational round-robin next-enabled-channel finder; inputs mask and cur, output nxt.

Test Plan:
- Default params; mask=0x05; span_cfg ch2=3'b111; BUSY model low 100 cycles after CNV rise; one trig_ext pulse → cnv high 4 cycles, 12 SCKI periods of 4 clk, sdi bits 1,010,111,0, conv_done once, cur_chan=2.
- Timer mode, period=500, mask=0xFF; run 8 triggers → cur_chan sequence 1..7,0, eight conv_done pulses, overrun_cnt=0.
- Period=50 (shorter than cycle length ~154) → overrun_cnt increments once per dropped trigger; exact value checked after 1000 cycles.
- BUSY held high → timeout_err=1 at CNV rise +200, no SCKI edges, cur_chan unchanged, next trigger still accepted.
- mask=0x00 with triggers → no cnv, overrun_cnt=0. mask changed 0x01→0x80 during SHIFT → next word targets ch0; the following cycle targets ch7.
- aresetn asserted during SHIFT → cnv=scki=sdi=0 that cycle, active=0, overrun_cnt=0.
